axi_lite_reg_responder: RTL and testbench
=========================================

Name: axi_lite_reg_responder

Overview:
AXI4-Lite slave responder holding a bank of 32-bit registers. It is the target end of the MMIO_AXI master port and replaces the slave VIP in BFM and system designs. It accepts single-beat writes and reads, applies byte strobes, and returns OKAY for in-range accesses and SLVERR for out-of-range ones. One outstanding write and one outstanding read are allowed, and each channel runs independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width.
NUM_REGS, 16, number of implemented registers. Must be ≤ 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.

Behaviour:
- Reset, on an ACLK edge with ARESET=1:
  - All registers clear to 0.
  - Both FSMs return to IDLE.
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - All READY outputs are 0 while ARESET=1.
- Reset mid-transaction discards pending AW/W/AR captures and responses; no register write occurs in that cycle.
- Register index = addr[C_S_AXI_ADDR_WIDTH-1:2]. addr[1:0] is ignored. Index ≥ NUM_REGS is out of range.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY=1 in W_IDLE and W_HAVE_W. WREADY=1 in W_IDLE and W_HAVE_AW. Both are 0 in W_RESP.
  - W_IDLE:
    - AW and W handshake in the same cycle → commit, go to W_RESP.
    - AW only → latch address, go to W_HAVE_AW.
    - W only → latch data and strobes, go to W_HAVE_W.
  - W_HAVE_AW: W handshake → commit, go to W_RESP.
  - W_HAVE_W: AW handshake → commit, go to W_RESP.
  - Commit:
    - In range: byte lanes with WSTRB[i]=1 are updated; lanes with WSTRB=0 keep their value; BRESP=2'b00.
    - Out of range: no update; BRESP=2'b10.
  - W_RESP: BVALID=1, asserted the cycle after commit. BVALID and BRESP hold stable until BREADY=1. The handshake cycle returns to W_IDLE, and BVALID is 0 the next cycle.
  - Latency from the final AW/W handshake to BVALID: 1 cycle.
- Read FSM states: R_IDLE, R_RESP.
  - ARREADY=1 only in R_IDLE.
  - On AR handshake: register RDATA from the addressed register, RRESP=00. Out of range: RDATA=0, RRESP=10. Go to R_RESP.
  - R_RESP: RVALID=1; RDATA and RRESP are stable until RREADY. Handshake returns to R_IDLE. Back-to-back reads sustain 1 read every 2 cycles.
- Simultaneous events:
  - A read captured in the same cycle as a write commit to the same register returns the pre-write value.
  - A later read returns the new value.
- WSTRB=4'b0000 in range: no change, BRESP=OKAY.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04 with AW and W together, WSTRB=F, BREADY=1 → BVALID one cycle later, BRESP=00. Read 0x04 → RDATA=0xDEADBEEF, RRESP=00.
- W first, AW 3 cycles later: 0x12345678 to 0x08, WSTRB=4'b0101 over prior 0xFFFFFFFF → read 0x08 = 0xFF34FF78. AWREADY=0 and WREADY=0 while BVALID=1.
- Write to 0x3C (index 15) OK. Write and read at index 16 (addr 0x40, with C_S_AXI_ADDR_WIDTH=7) → BRESP=10, RRESP=10, RDATA=0, no register changed.
- BREADY=0 for 5 cycles after a write → BVALID and BRESP held; no new AW/W accepted. RREADY stalled 4 cycles → RDATA stable.
- Read 0x04 issued in the write-commit cycle of 0x00000001 to 0x04 (prior 0xDEADBEEF) → returns 0xDEADBEEF. Next read returns 0x00000001.
- ARESET pulsed while BVALID=1 and RVALID=1 → next cycle both are 0, READYs are 0 during reset, and every register reads 0 afterwards.

Source files
------------

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite slave responder backed by a bank of 32-bit registers.
// Write and read channels run independently, each with one outstanding
// transaction. In-range accesses return OKAY; out-of-range accesses
// return SLVERR, with no register update on writes and zero data on reads.
module axi_lite_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // Write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // Write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // Write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // Read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int AW        = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W    = DW / 8;
  localparam int IDX_W     = AW - 2;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // One extra bit so NUM_REGS == 2**IDX_W is representable in the compare.
  localparam logic [IDX_W:0] NUM_REGS_CMP = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_e;

  // ---------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------
  logic [DW-1:0] regs_q [NUM_REGS];

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  wstate_e              wstate_q, wstate_d;
  logic [AW-1:0]        aw_addr_q, aw_addr_d;
  logic [DW-1:0]        w_data_q, w_data_d;
  logic [STRB_W-1:0]    w_strb_q, w_strb_d;
  logic [1:0]           bresp_q, bresp_d;

  logic                 aw_hs, w_hs;
  logic                 commit;
  logic [AW-1:0]        commit_addr;
  logic [DW-1:0]        commit_data;
  logic [STRB_W-1:0]    commit_strb;
  logic                 commit_in_range;
  logic [REG_IDX_W-1:0] commit_idx;

  // READY depends only on state, and is forced low while reset is asserted.
  assign S_AXI_AWREADY = !ARESET && (wstate_q == W_IDLE || wstate_q == W_HAVE_W);
  assign S_AXI_WREADY  = !ARESET && (wstate_q == W_IDLE || wstate_q == W_HAVE_AW);
  assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID  && S_AXI_WREADY;

  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;

  // Write FSM next state: capture AW/W in either order and commit once both are present.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    wstate_d    = wstate_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_addr = S_AXI_AWADDR;
    commit_data = S_AXI_WDATA;
    commit_strb = S_AXI_WSTRB;

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          aw_addr_d = S_AXI_AWADDR;
          wstate_d  = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_d = S_AXI_WDATA;
          w_strb_d = S_AXI_WSTRB;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        commit_addr = aw_addr_q;
        if (w_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        commit_data = w_data_q;
        commit_strb = w_strb_q;
        if (aw_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    commit_in_range = ({1'b0, commit_addr[AW-1:2]} < NUM_REGS_CMP);
    commit_idx      = commit_addr[REG_IDX_W+1:2];

    if (commit) begin
      bresp_d = commit_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Write FSM state and capture registers.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Register bank update: strobed byte lanes of an in-range commit.
  always_ff @(posedge ACLK) begin
    // NOTE: this bank is built from flops and must read as zero after reset, so every entry is reset explicitly.
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit && commit_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (commit_strb[b]) begin
          regs_q[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  rstate_e              rstate_q, rstate_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 ar_hs;
  logic                 ar_in_range;
  logic [REG_IDX_W-1:0] ar_idx;

  assign S_AXI_ARREADY = !ARESET && (rstate_q == R_IDLE);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_in_range   = ({1'b0, S_AXI_ARADDR[AW-1:2]} < NUM_REGS_CMP);
  assign ar_idx        = S_AXI_ARADDR[REG_IDX_W+1:2];

  assign S_AXI_RVALID  = (rstate_q == R_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  // Read FSM next state: sample the bank on AR handshake and hold until RREADY.
  // The bank is sampled before any same-cycle write lands, so a colliding read sees the old value.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d  = ar_in_range ? regs_q[ar_idx] : '0;
          rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read FSM state and response registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // Protection bits and byte offset carry no meaning for this register bank.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed plus randomized bench for axi_lite_reg_responder, built with a
// 7-bit address so indices 16..31 exercise the out-of-range path.
module tb_axi_lite_reg_responder;

  localparam int AW = 7;
  localparam int NR = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  axi_lite_reg_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the register bank as a plain array.
  logic [31:0] model [NR];
  logic [31:0] rd;
  logic [1:0]  rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [AW-1:0] a);
    return int'(a[AW-1:2]) < NR;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
    return in_range(a) ? model[int'(a[AW-1:2])] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (in_range(a))
      model[int'(a[AW-1:2])] = (model[int'(a[AW-1:2])] & ~mask) | (d & mask);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Write with independent AW/W start delays and a BREADY stall; all checks inline.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_stall);
    bit   aw_done = 0;
    bit   w_done  = 0;
    int   cyc     = 0;
    logic aw_hs, w_hs;
    logic [1:0] er;
    er = exp_resp(a);
    S_AXI_AWADDR = a;
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    while (!(aw_done && w_done) && cyc < 20) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done  && (cyc >= w_dly);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_handshake_done", 32'({aw_done, w_done}), 32'h3);
    check("bvalid_1cycle", 32'(S_AXI_BVALID), 32'h1);
    check("bresp", 32'(S_AXI_BRESP), 32'(er));
    for (int i = 0; i < b_stall; i++) begin
      check("awready_in_resp", 32'(S_AXI_AWREADY), 32'h0);
      check("wready_in_resp", 32'(S_AXI_WREADY), 32'h0);
      tick();
      check("bvalid_held", 32'(S_AXI_BVALID), 32'h1);
      check("bresp_held", 32'(S_AXI_BRESP), 32'(er));
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bvalid_drop", 32'(S_AXI_BVALID), 32'h0);
    model_write(a, d, s);
  endtask

  // Read with an RREADY stall; returns the captured data and response.
  task automatic axi_read(input logic [AW-1:0] a, input int r_stall,
                          output logic [31:0] d, output logic [1:0] r);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    check("arready_idle", 32'(S_AXI_ARREADY), 32'h1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rvalid", 32'(S_AXI_RVALID), 32'h1);
    check("arready_in_resp", 32'(S_AXI_ARREADY), 32'h0);
    d = S_AXI_RDATA;
    r = S_AXI_RRESP;
    for (int i = 0; i < r_stall; i++) begin
      tick();
      check("rvalid_held", 32'(S_AXI_RVALID), 32'h1);
      check("rdata_stable", S_AXI_RDATA, d);
      check("rresp_stable", 32'(S_AXI_RRESP), 32'(r));
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rvalid_drop", 32'(S_AXI_RVALID), 32'h0);
  endtask

  task automatic read_check(input logic [AW-1:0] a, input int r_stall);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, r_stall, d, r);
    check($sformatf("rdata@%h", a), d, exp_rdata(a));
    check($sformatf("rresp@%h", a), 32'(r), 32'(exp_resp(a)));
  endtask

  task automatic sweep();
    for (int i = 0; i < NR; i++) read_check(AW'(i * 4), 0);
  endtask

  initial begin
    ARESET        = 1'b1;
    S_AXI_AWADDR  = '0;  S_AXI_AWPROT = 3'b0;  S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;  S_AXI_WSTRB  = 4'h0;  S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;  S_AXI_ARPROT = 3'b0;  S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    // Reset state
    tick(); tick();
    check("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    check("rst_wready",  32'(S_AXI_WREADY),  32'h0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    check("rst_bvalid",  32'(S_AXI_BVALID),  32'h0);
    check("rst_rvalid",  32'(S_AXI_RVALID),  32'h0);
    check("rst_rdata",   S_AXI_RDATA,        32'h0);
    ARESET = 1'b0;
    tick();
    check("idle_awready", 32'(S_AXI_AWREADY), 32'h1);
    check("idle_wready",  32'(S_AXI_WREADY),  32'h1);
    check("idle_arready", 32'(S_AXI_ARREADY), 32'h1);

    // AW and W together
    axi_write(7'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(7'h04, 0, rd, rr);
    check("deadbeef", rd, 32'hDEADBEEF);
    check("deadbeef_resp", 32'(rr), 32'h0);

    // W first, AW three cycles later, partial strobes
    axi_write(7'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(7'h08, 32'h12345678, 4'b0101, 3, 0, 0);
    axi_read(7'h08, 0, rd, rr);
    check("strb_merge", rd, 32'hFF34FF78);
    // AW first, W later
    axi_write(7'h0C, 32'hA1B2C3D4, 4'b1010, 0, 2, 0);
    read_check(7'h0C, 0);

    // Top in-range register and first out-of-range index
    axi_write(7'h3C, 32'hA5A50F0F, 4'hF, 0, 0, 0);
    read_check(7'h3C, 0);
    axi_write(7'h40, 32'h11111111, 4'hF, 0, 0, 0);
    axi_read(7'h40, 0, rd, rr);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", 32'(rr), 32'h2);
    read_check(7'h7F, 0);
    sweep();

    // Response back-pressure
    axi_write(7'h10, 32'h0BADF00D, 4'hF, 0, 0, 5);
    read_check(7'h10, 4);

    // Zero strobes leave the register unchanged
    axi_write(7'h08, 32'h00000000, 4'h0, 0, 0, 0);
    axi_read(7'h08, 0, rd, rr);
    check("strb0_unchanged", rd, 32'hFF34FF78);

    // Read captured in the write-commit cycle sees the old value
    axi_write(7'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = 7'h04; S_AXI_WDATA = 32'h00000001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 7'h04; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("coll_bvalid", 32'(S_AXI_BVALID), 32'h1);
    check("coll_rvalid", 32'(S_AXI_RVALID), 32'h1);
    check("coll_old_value", S_AXI_RDATA, 32'hDEADBEEF);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    model_write(7'h04, 32'h00000001, 4'hF);
    axi_read(7'h04, 0, rd, rr);
    check("coll_new_value", rd, 32'h00000001);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = {5'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        read_check(a, $urandom_range(0, 2));
    end
    sweep();

    // Reset with both responses pending
    axi_write(7'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = 7'h44; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 7'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    check("pre_rst_bvalid", 32'(S_AXI_BVALID), 32'h1);
    check("pre_rst_bresp", 32'(S_AXI_BRESP), 32'h2);
    check("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'h1);
    check("pre_rst_rdata", S_AXI_RDATA, 32'hCAFEF00D);
    ARESET = 1'b1;
    S_AXI_AWADDR = 7'h14; S_AXI_WDATA = 32'h77;
    tick();
    check("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
    check("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
    check("mid_rst_bresp", 32'(S_AXI_BRESP), 32'h0);
    check("mid_rst_rdata", S_AXI_RDATA, 32'h0);
    check("mid_rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    check("mid_rst_wready", 32'(S_AXI_WREADY), 32'h0);
    check("mid_rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    tick();
    ARESET = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
